// File: rtl/mul_div_unit.sv
`default_nettype none
// =============================================================================
// mul_div_unit: iterative N-cycle multiply / restoring divide with HI/LO results.
// Optional two's-complement support under macro MDU_SIGNED_EN.    Rev 1.0
// =============================================================================

module mul_div_unit #(
  parameter int inst_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 op_div,
  input  logic                 op_signed,
  input  logic [inst_SIZE-1:0] read_data_1,
  input  logic [inst_SIZE-1:0] read_data_2,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [inst_SIZE-1:0] hi,
  output logic [inst_SIZE-1:0] lo
);

  localparam int N     = inst_SIZE;
  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     a_q, a_d, b_q, b_d;
  logic [N-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic             div_q, div_d, dz_q, dz_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  logic [N-1:0]     mag1, mag2;

`ifdef MDU_SIGNED_EN
  logic             sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic [2*N-1:0]   prod_neg;

  assign mag1     = (op_signed && read_data_1[N-1]) ? -read_data_1 : read_data_1;
  assign mag2     = (op_signed && read_data_2[N-1]) ? -read_data_2 : read_data_2;
  assign prod_neg = -{hi_q, lo_q};
`else
  logic unused_op_signed;
  assign unused_op_signed = op_signed;
  assign mag1 = read_data_1;
  assign mag2 = read_data_2;
`endif

  // The first iteration starts from the operands directly, so hi/lo are only
  // written while the unit is working.
  logic         first;
  logic [N-1:0] src_hi, src_lo;
  assign first  = (cnt_q == '0);
  assign src_hi = first ? '0 : hi_q;
  assign src_lo = first ? (div_q ? a_q : b_q) : lo_q;

  logic [N:0]   mul_sum;
  assign mul_sum = {1'b0, src_hi} + (src_lo[0] ? {1'b0, a_q} : '0);

  logic [N:0]   rem;
  logic         rem_ge;
  logic [N-1:0] rem_sub;
  assign rem     = {src_hi, src_lo[N-1]};
  assign rem_ge  = (rem >= {1'b0, b_q});
  assign rem_sub = rem[N-1:0] - b_q;

  logic [N-1:0] step_hi, step_lo;
  assign step_hi = div_q ? (rem_ge ? rem_sub : rem[N-1:0]) : mul_sum[N:1];
  assign step_lo = div_q ? {src_lo[N-2:0], rem_ge} : {mul_sum[0], src_lo[N-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
`ifdef MDU_SIGNED_EN
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          busy_d  = 1'b1;
          dbz_d   = 1'b0;
          cnt_d   = '0;
          div_d   = op_div;
          dz_d    = op_div && (read_data_2 == '0);
          // A zero divisor returns the dividend untouched in hi.
          a_d     = (op_div && (read_data_2 == '0)) ? read_data_1 : mag1;
          b_d     = mag2;
`ifdef MDU_SIGNED_EN
          sgn_d   = op_signed;
          qneg_d  = op_signed && (read_data_1[N-1] ^ read_data_2[N-1]);
          rneg_d  = op_signed && read_data_1[N-1];
`endif
        end
      end
      CALC: begin
        if (dz_q) begin
          hi_d    = a_q;
          lo_d    = '1;
          dbz_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`ifdef MDU_SIGNED_EN
            if (sgn_q) begin
              state_d = FIX;
              busy_d  = 1'b1;
              done_d  = 1'b0;
            end
`endif
          end
        end
      end
      FIX: begin
`ifdef MDU_SIGNED_EN
        if (!div_q && qneg_q) begin
          {hi_d, lo_d} = prod_neg;
        end
        if (div_q && qneg_q) begin
          lo_d = -lo_q;
        end
        if (div_q && rneg_q) begin
          hi_d = -hi_q;
        end
`endif
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef MDU_SIGNED_EN
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
`ifdef MDU_SIGNED_EN
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// =============================================================================
// tb_mul_div_unit: directed vectors into a scoreboard; a negedge monitor checks
// every done pulse for hi/lo/div_by_zero, latency and busy length.    Rev 1.0
// =============================================================================

module tb_mul_div_unit;

  localparam int N  = 16;
  localparam int LU = 17;
`ifdef MDU_SIGNED_EN
  localparam int LS = 18;
`else
  localparam int LS = 17;
`endif
  localparam int LZ = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op_div = 1'b0;
  logic         op_signed = 1'b0;
  logic [N-1:0] rd1 = '0;
  logic [N-1:0] rd2 = '0;
  logic         busy, done, dbz;
  logic [N-1:0] hi, lo;

  mul_div_unit #(.inst_SIZE(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_div(op_div),
    .op_signed(op_signed), .read_data_1(rd1), .read_data_2(rd2),
    .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         dbz;
    int           done_cyc;
    int           busy_cycles;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   busy_cnt   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no result", cyc);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_hi"}, 32'(hi), 32'(e.hi));
          chk({e.name, "_lo"}, 32'(lo), 32'(e.lo));
          chk({e.name, "_dbz"}, 32'(dbz), 32'(e.dbz));
          chk({e.name, "_latency"}, 32'(cyc), 32'(e.done_cyc));
          chk({e.name, "_busy_len"}, 32'(busy_cnt), 32'(e.busy_cycles));
        end
        busy_cnt = 0;
      end
    end
  end

  // Called at a negedge in IDLE; start is sampled at the next posedge (T0).
  task automatic issue(input logic d, input logic s, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [N-1:0] eh,
                       input logic [N-1:0] el, input logic edbz, input int lat,
                       input int poke, input string name);
    exp_t e;
    bit   got;
    e.hi = eh;
    e.lo = el;
    e.dbz = edbz;
    e.done_cyc = cyc + lat;
    e.busy_cycles = lat - 1;
    e.name = name;
    sb.push_back(e);
    op_div = d;
    op_signed = s;
    rd1 = a;
    rd2 = b;
    start = 1'b1;
    got = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (i == 1) chk({name, "_dbz_cleared"}, 32'(dbz), 32'd0);
      start = (i == poke);
      op_div = ~d;
      rd1 = ~a;
      rd2 = ~b;
      if (done) got = 1'b1;
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: got no done in 40 cycles, expected done", name);
      sb.delete();
    end else begin
      // start during the DONE cycle must be ignored
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({name, "_done_start_ignored"}, 32'(busy), 32'd0);
      chk({name, "_hold_hi"}, 32'(hi), 32'(eh));
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_dbz", 32'(dbz), 32'd0);
    chk("reset_hi", 32'(hi), 32'd0);
    chk("reset_lo", 32'(lo), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b0, 1'b0, 16'h00FF, 16'h0101, 16'h0000, 16'hFFFF, 1'b0, LU, 0, "mul_ff_101");
    issue(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, LU, 0, "mul_max_u");
`ifdef MDU_SIGNED_EN
    issue(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 1'b0, LS, 0, "mul_max_s");
`else
    issue(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, LS, 0, "mul_max_s");
`endif
    issue(1'b1, 1'b0, 16'h0064, 16'h0007, 16'h0002, 16'h000E, 1'b0, LU, 5, "div_100_7");
    issue(1'b1, 1'b0, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, LZ, 0, "div_zero");
    issue(1'b1, 1'b0, 16'h00FF, 16'h0010, 16'h000F, 16'h000F, 1'b0, LU, 0, "div_after_dz");
`ifdef MDU_SIGNED_EN
    issue(1'b1, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0, LS, 0, "div_m7_2");
`else
    issue(1'b1, 1'b1, 16'hFFF9, 16'h0002, 16'h0001, 16'h7FFC, 1'b0, LS, 0, "div_m7_2");
`endif
    issue(1'b1, 1'b0, 16'h0005, 16'h0009, 16'h0005, 16'h0000, 1'b0, LU, 0, "div_small");
    issue(1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, LU, 0, "div_by_one");
    issue(1'b0, 1'b0, 16'h0000, 16'hABCD, 16'h0000, 16'h0000, 1'b0, LU, 0, "mul_zero");
    issue(1'b1, 1'b1, 16'hFFF0, 16'h0000, 16'hFFF0, 16'hFFFF, 1'b1, LZ, 0, "div_zero_s");
`ifdef MDU_SIGNED_EN
    issue(1'b1, 1'b1, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, LS, 0, "div_ovf");
    issue(1'b0, 1'b1, 16'h0003, 16'hFFFE, 16'hFFFF, 16'hFFFA, 1'b0, LS, 0, "mul_neg");
`else
    issue(1'b1, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, LS, 0, "div_ovf");
    issue(1'b0, 1'b1, 16'h0003, 16'hFFFE, 16'h0002, 16'hFFFA, 1'b0, LS, 0, "mul_neg");
`endif

    // Reset in the middle of a multiply.
    op_div = 1'b0;
    op_signed = 1'b0;
    rd1 = 16'h1234;
    rd2 = 16'h5678;
    start = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_hi", 32'(hi), 32'd0);
    chk("abort_lo", 32'(lo), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 1'b0, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 1'b0, LU, 0, "mul_after_rst");

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
